// File: rtl/sweep_pkg.sv
// Shared widths, sweep size and FSM state type for the operand sweep checker.
package sweep_pkg;
   localparam int unsigned OP_W      = 3;
   localparam int unsigned NUM_PAIRS = 64;
   localparam int unsigned ERR_W     = 7;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } sweep_state_t;
endpackage

// File: rtl/sweep_ref_adder.sv
// Combinational reference adder: OP_W-bit sum with the carry-out discarded.
module sweep_ref_adder
   import sweep_pkg::*;
(
   input  logic [OP_W-1:0] a,
   input  logic [OP_W-1:0] b,
   output logic [OP_W-1:0] sum
);
   always_comb begin
      sum = a + b;
   end
endmodule

// File: rtl/operand_sweep_checker.sv
// Exhaustively sweeps all 3-bit operand pairs through an external adder and counts mismatches.
// Optional macro SWEEP_STOP_ON_FAIL_EN: stop the sweep at the first mismatch.
module operand_sweep_checker
   import sweep_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [OP_W-1:0]  dut_sum,
   output logic [OP_W-1:0]  op_a,
   output logic [OP_W-1:0]  op_b,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [OP_W-1:0]  fail_a,
   output logic [OP_W-1:0]  fail_b
);
   localparam logic [1:0] SETTLE_LAST = 2'(SETTLE_CYCLES - 1);

   sweep_state_t        state;
   logic [1:0]          settle_cnt;
   logic [OP_W-1:0]     exp_sum;
   logic                mismatch;
   logic                last_pair;
   logic [2*OP_W-1:0]   pair_next;

   sweep_ref_adder u_ref (
      .a   (op_a),
      .b   (op_b),
      .sum (exp_sum)
   );

   always_comb begin
      mismatch  = (dut_sum != exp_sum);
      last_pair = (op_a == '1) && (op_b == '1);
      pair_next = {op_a, op_b} + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         settle_cnt <= '0;
         op_a       <= '0;
         op_b       <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_a     <= '0;
         fail_b     <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state      <= DRIVE;
                  settle_cnt <= '0;
                  op_a       <= '0;
                  op_b       <= '0;
                  err_count  <= '0;
                  fail_a     <= '0;
                  fail_b     <= '0;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  pass       <= 1'b0;
               end
            end
            DRIVE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  settle_cnt <= '0;
                  state      <= SAMPLE;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            SAMPLE: begin
               if (mismatch) begin
                  err_count <= err_count + 1'b1;
                  if (err_count == '0) begin
                     fail_a <= op_a;
                     fail_b <= op_b;
                  end
               end
`ifdef SWEEP_STOP_ON_FAIL_EN
               if (mismatch || last_pair) begin
`else
               if (last_pair) begin
`endif
                  // pass is latched on DONE entry, so fold in this cycle's compare result
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= !mismatch && (err_count == '0);
               end else begin
                  {op_a, op_b} <= pair_next;
                  state        <= DRIVE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
